// File: rtl/uart_pkg.sv
// Shared UART definitions for the two-board click link (tx and rx sides).
//   tx_state_t         : transmitter FSM state encoding
//   DEFAULT_BAUD       : line rate common to both ends of the link
//   DEFAULT_CLICK_BYTE : payload byte representing one click
package uart_pkg;

  localparam int unsigned DEFAULT_BAUD       = 115_200;
  localparam logic [7:0]  DEFAULT_CLICK_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 and pulses tick on the last count.
//   clk, rst (async active-low) : clock / reset
//   restart                     : hold the count at zero (state entry)
//   tick                        : high while the count equals DIV-1
module uart_baud_gen #(
  parameter int unsigned DIV = 564
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // Wraps on its own at every bit boundary, so back-to-back bits need no restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_click_tx.sv
// Click-to-UART transmitter: each click becomes one 8N1 frame of CLICK_BYTE.
// Clicks arriving mid-frame are queued in a saturating counter and sent
// back-to-back.
//   clk, rst (async active-low) : clock / reset
//   click                       : single-cycle synchronised click event
//   tx_out                      : UART line, idle high, LSB first
//   busy                        : high while a frame is on the line
//   dropped                     : one-cycle pulse per discarded click
module uart_click_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 65_000_000,
  parameter int unsigned BAUD        = DEFAULT_BAUD,
  parameter logic [7:0]  CLICK_BYTE  = DEFAULT_CLICK_BYTE,
  parameter int unsigned MAX_PENDING = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic click,
  output logic tx_out,
  output logic busy,
  output logic dropped
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned PW  = $clog2(MAX_PENDING + 1);

  tx_state_t     state, state_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic [PW-1:0] pending, pending_d;
  logic          tick;
  logic          deq;
  logic          accept;
  logic          tx_d, busy_d, dropped_d;

  // Counter sits at zero in IDLE so every frame's START begins at count 0.
  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(state == IDLE),
    .tick   (tick)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      pending <= '0;
      tx_out  <= 1'b1;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state   <= state_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      pending <= pending_d;
      tx_out  <= tx_d;
      busy    <= busy_d;
      dropped <= dropped_d;
    end
  end

  // Next state, frame datapath and pending-click bookkeeping.
  always_comb begin
    state_d   = state;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    deq       = 1'b0;
    unique case (state)
      IDLE: begin
        // A click seen here starts the frame itself and is not queued.
        if (click || (pending != '0)) begin
          state_d = START;
          deq     = !click;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = {1'b0, shreg[7:1]};
          end
        end
      end
      STOP: begin
        // This cycle's click counts toward the queue before deciding.
        if (tick) begin
          if ((pending != '0) || click) begin
            state_d = START;
            deq     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == START) && (state != START)) begin
      shreg_d   = CLICK_BYTE;
      bit_idx_d = 3'd0;
    end

    // A dequeue in the same cycle frees a slot for a click at saturation.
    accept = click && (state != IDLE) &&
             ((pending != PW'(MAX_PENDING)) || deq);

    pending_d = pending;
    if (accept && !deq) begin
      pending_d = pending + PW'(1);
    end else if (deq && !accept) begin
      pending_d = pending - PW'(1);
    end
  end

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    tx_d      = 1'b1;
    busy_d    = (state_d != IDLE);
    dropped_d = click && (state != IDLE) && !accept;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_click_tx.sv
// Self-checking bench for uart_click_tx at DIV=10 (CLK_FREQ=1000, BAUD=100).
module tb_uart_click_tx;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned BAUD     = 100;
  localparam int unsigned MAXP     = 15;
  localparam logic [7:0]  BYTE     = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic click = 1'b0;
  logic tx_out, busy, dropped;

  uart_click_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .CLICK_BYTE (BYTE),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .click  (click),
    .tx_out (tx_out),
    .busy   (busy),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int first;
    int last;
    int tx;
    int bsy;
  } seg_t;

  seg_t       segs[11];
  int         tests = 0;
  int         fails = 0;
  int         frames_rx = 0;
  logic [7:0] exp_q[$];
  int         sched_q[$];
  int         tx_tr[$];
  int         busy_tr[$];
  int         pend_tr[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame decoder: samples mid-bit and compares bytes against the scoreboard.
  task automatic monitor();
    bit         active = 1'b0;
    int         cnt = 0;
    logic [7:0] sh = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx_out == 1'b0) begin
          active = 1'b1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        check("mon_busy_in_frame", int'(busy), 1);
        if (cnt == 5) check("mon_start_bit", int'(tx_out), 0);
        if (cnt >= 15 && cnt <= 85 && (cnt % 10) == 5) sh[3'((cnt - 15) / 10)] = tx_out;
        if (cnt == 95) check("mon_stop_bit", int'(tx_out), 1);
        if (cnt == 99) begin
          active = 1'b0;
          frames_rx++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL mon_unexpected_frame: got byte %0h expected no frame", sh);
          end else begin
            check("mon_byte", int'(sh), int'(exp_q.pop_front()));
          end
        end
      end
    end
  endtask

  // Drive clicks at the cycles in sched_q and trace outputs until idle.
  task automatic run_sched(input int budget, output int bcyc, output int drops,
                           output int pmax, output int done);
    bcyc = 0; drops = 0; pmax = 0; done = 0;
    tx_tr.delete(); busy_tr.delete(); pend_tr.delete();
    for (int c = 0; c < budget; c++) begin
      if (sched_q.size() > 0 && sched_q[0] == c) begin
        click = 1'b1;
        sched_q.delete(0);
      end
      @(posedge clk); #1;
      click = 1'b0;
      tx_tr.push_back(int'(tx_out));
      busy_tr.push_back(int'(busy));
      pend_tr.push_back(int'(dut.pending));
      if (busy) bcyc++;
      if (dropped) drops++;
      if (int'(dut.pending) > pmax) pmax = int'(dut.pending);
      if (!busy && sched_q.size() == 0) begin
        done = 1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcyc, drops, pmax, done, f0;

    segs[0]  = '{0,   9,   0, 1};
    segs[1]  = '{10,  19,  1, 1};
    segs[2]  = '{20,  29,  0, 1};
    segs[3]  = '{30,  39,  1, 1};
    segs[4]  = '{40,  49,  0, 1};
    segs[5]  = '{50,  59,  0, 1};
    segs[6]  = '{60,  69,  1, 1};
    segs[7]  = '{70,  79,  0, 1};
    segs[8]  = '{80,  89,  1, 1};
    segs[9]  = '{90,  99,  1, 1};
    segs[10] = '{100, 100, 1, 0};

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", int'(tx_out), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_dropped", int'(dropped), 0);
    check("rst_pending", int'(dut.pending), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Single click: waveform table
    f0 = frames_rx;
    exp_q.push_back(BYTE);
    sched_q = {0};
    run_sched(400, bcyc, drops, pmax, done);
    check("single_done", done, 1);
    check("single_busy_cycles", bcyc, 100);
    for (int s = 0; s < 11; s++) begin
      for (int c = segs[s].first; c <= segs[s].last; c++) begin
        if (c < tx_tr.size()) begin
          check($sformatf("single_tx_c%0d", c), tx_tr[c], segs[s].tx);
          check($sformatf("single_busy_c%0d", c), busy_tr[c], segs[s].bsy);
        end else begin
          check($sformatf("single_trace_len_c%0d", c), tx_tr.size(), c + 1);
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("single_frames", frames_rx - f0, 1);

    // Queued clicks at 0, 20, 40
    f0 = frames_rx;
    repeat (3) exp_q.push_back(BYTE);
    sched_q = {0, 20, 40};
    run_sched(1000, bcyc, drops, pmax, done);
    check("queued_done", done, 1);
    check("queued_busy_cycles", bcyc, 300);
    check("queued_pending_max", pmax, 2);
    check("queued_dropped", drops, 0);
    repeat (3) @(posedge clk);
    #1;
    check("queued_frames", frames_rx - f0, 3);

    // Saturation: start click plus 17 clicks during the first frame
    f0 = frames_rx;
    repeat (16) exp_q.push_back(BYTE);
    sched_q = {};
    for (int i = 0; i < 18; i++) sched_q.push_back(2 * i);
    run_sched(3000, bcyc, drops, pmax, done);
    check("sat_done", done, 1);
    check("sat_pending_max", pmax, 15);
    check("sat_dropped", drops, 2);
    check("sat_busy_cycles", bcyc, 1600);
    repeat (3) @(posedge clk);
    #1;
    check("sat_frames", frames_rx - f0, 16);

    // Click coincident with last STOP cycle while one click is pending
    f0 = frames_rx;
    repeat (3) exp_q.push_back(BYTE);
    sched_q = {0, 20, 100};
    run_sched(1000, bcyc, drops, pmax, done);
    check("deq_done", done, 1);
    if (pend_tr.size() > 100) begin
      check("deq_pending_before", pend_tr[99], 1);
      check("deq_pending_after", pend_tr[100], 1);
      check("deq_tx_start", tx_tr[100], 0);
      check("deq_busy_held", busy_tr[100], 1);
    end else begin
      check("deq_trace_len", pend_tr.size(), 101);
    end
    check("deq_busy_cycles", bcyc, 300);
    check("deq_dropped", drops, 0);
    repeat (3) @(posedge clk);
    #1;
    check("deq_frames", frames_rx - f0, 3);

    // Reset mid-frame, then click on the first edge after release
    f0 = frames_rx;
    exp_q.push_back(BYTE);
    click = 1'b1;
    @(posedge clk); #1;
    click = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
    end
    check("midrst_pre_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_tx", int'(tx_out), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_pending", int'(dut.pending), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    click = 1'b1;
    exp_q.push_back(BYTE);
    @(posedge clk); #1;
    click = 1'b0;
    check("post_rst_tx", int'(tx_out), 0);
    check("post_rst_busy", int'(busy), 1);
    sched_q = {};
    run_sched(400, bcyc, drops, pmax, done);
    check("post_rst_done", done, 1);
    check("post_rst_busy_cycles", bcyc, 99);
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_frames", frames_rx - f0, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    check("total_frames", frames_rx, 24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
